// File: rtl/axis_line_window.sv
// axis_line_window: emits a ROWS-tall vertical pixel column per beat from an AXI4-Stream video frame.
// Optional: define LINE_WINDOW_BORDER_REPLICATE_EN to edge-replicate the bottom border instead of zero pad.
module axis_line_window #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 3,
  parameter int MAX_WIDTH  = 2048,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_areset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tuser,
  output logic [ROWS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic                       frame_err
);
  localparam int CW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int LW = $clog2(IMG_HEIGHT + 1);
  localparam int FW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              col_q, col_d, wlast_q, wlast_d;
  logic [LW-1:0]              line_q, line_d;
  logic [FW-1:0]              fl_q, fl_d;
  logic                       first_q, first_d, err_q, err_d;
  logic                       mvld_q, mvld_d, mlast_q, mlast_d, muser_q, muser_d;
  logic [ROWS*DATA_WIDTH-1:0] mdata_q, mdata_d, beat_data;

  logic                  adv, rdy, acc, sof, px_acc, in_run, line0, at_wlast, line_end, len_err;
  logic                  flush_beat, flush_done, beat, mem_we;
  logic [CW-1:0]         cur_col;
  logic [LW-1:0]         cur_line;
  logic [DATA_WIDTH-1:0] mem_in, pad;
  logic [DATA_WIDTH-1:0] rd [ROWS-1];

  always_comb begin
    adv = !mvld_q || m_axis_tready;
    case (state_q)
      IDLE:    rdy = 1'b1;
      FLUSH:   rdy = 1'b0;
      default: rdy = adv;
    endcase
  end

  assign s_axis_tready = rdy && !s_axis_areset;
  assign acc        = s_axis_tvalid && s_axis_tready;
  // A tuser beat always restarts the frame as line 0, col 0.
  assign sof        = acc && s_axis_tuser;
  assign cur_col    = sof ? '0 : col_q;
  assign cur_line   = sof ? '0 : line_q;
  assign line0      = (cur_line == '0);
  assign at_wlast   = line0 ? (cur_col == COL_MAX) : (cur_col == wlast_q);
  assign line_end   = at_wlast || (line0 && s_axis_tlast);
  assign len_err    = line0 ? (at_wlast && !s_axis_tlast) : (s_axis_tlast != at_wlast);
  assign px_acc     = sof || (acc && (state_q == FILL || state_q == RUN));
  assign in_run     = !sof && (state_q == RUN);
  assign flush_done = (state_q == FLUSH) && (fl_q == FW'(ROWS));
  assign flush_beat = (state_q == FLUSH) && adv && !flush_done;
  assign beat       = (px_acc && in_run) || flush_beat;
  assign mem_we     = px_acc || flush_beat;
  assign mem_in     = flush_beat ? '0 : s_axis_tdata;

  // Read-before-write shift: memory k holds the line k+1 rows above the current one.
  for (genvar k = 0; k < ROWS - 1; k++) begin : g_line
    logic [DATA_WIDTH-1:0] mem [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] wr;
    if (k == 0) begin : g_head
      assign wr = mem_in;
    end else begin : g_tail
      assign wr = rd[k-1];
    end
    assign rd[k] = mem[cur_col];
    always_ff @(posedge s_axis_aclk) begin
      if (mem_we) mem[cur_col] <= wr;
    end
  end

  always_comb begin
    pad = '0;
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    for (int j = 0; j < ROWS - 1; j++)
      if (fl_q == FW'(j + 1)) pad = rd[j];
`endif
    beat_data = '0;
    beat_data[DATA_WIDTH-1:0] = s_axis_tdata;
    for (int k = 1; k < ROWS; k++) beat_data[k*DATA_WIDTH +: DATA_WIDTH] = rd[k-1];
    if (state_q == FLUSH)
      for (int k = 0; k < ROWS - 1; k++)
        if (FW'(k) < fl_q) beat_data[k*DATA_WIDTH +: DATA_WIDTH] = pad;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    wlast_d = wlast_q;
    fl_d    = fl_q;
    first_d = first_q;
    err_d   = err_q;
    mvld_d  = mvld_q;
    mlast_d = mlast_q;
    muser_d = muser_q;
    mdata_d = mdata_q;
    if (px_acc) begin
      col_d  = line_end ? '0 : cur_col + 1'b1;
      line_d = line_end ? cur_line + 1'b1 : cur_line;
      if (line_end && line0) wlast_d = cur_col;
      if (sof) begin
        state_d = FILL;
        first_d = 1'b1;
        err_d   = 1'b0;
      end
      if (len_err) err_d = 1'b1;
      if (line_end && !in_run && cur_line == LW'(ROWS - 2)) state_d = RUN;
      if (line_end && in_run && cur_line == LW'(IMG_HEIGHT - 1)) begin
        state_d = FLUSH;
        col_d   = '0;
        line_d  = '0;
        fl_d    = FW'(1);
      end
    end
    if (flush_beat) begin
      if (col_q == wlast_q) begin
        col_d = '0;
        fl_d  = fl_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // Leave FLUSH only once the final flush beat has left the output register.
    if (flush_done && adv) state_d = IDLE;
    if (adv) begin
      mvld_d = beat;
      if (beat) begin
        mdata_d = beat_data;
        mlast_d = flush_beat ? (col_q == wlast_q) : line_end;
        muser_d = first_q;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
      wlast_q <= '0;
      fl_q    <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      mvld_q  <= 1'b0;
      mlast_q <= 1'b0;
      muser_q <= 1'b0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      wlast_q <= wlast_d;
      fl_q    <= fl_d;
      first_q <= first_d;
      err_q   <= err_d;
      mvld_q  <= mvld_d;
      mlast_q <= mlast_d;
      muser_q <= muser_d;
      mdata_q <= mdata_d;
    end
  end

  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvld_q;
  assign m_axis_tlast  = mlast_q;
  assign m_axis_tuser  = muser_q;
  assign frame_err     = err_q;
endmodule

// File: tb/tb_axis_line_window.sv
// tb_axis_line_window: scoreboard and spot-table bench for axis_line_window (ROWS=3 and ROWS=5 instances).
`timescale 1ns/1ps
module tb_axis_line_window;
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  typedef struct { logic [63:0] d; logic l; logic u; } beat_t;
  typedef struct { int idx; logic [23:0] dz; logic [23:0] dr; logic l; logic u; } spot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  a_tdata = '0, b_tdata = '0;
  logic        a_tvalid = 1'b0, a_tlast = 1'b0, a_tuser = 1'b0, a_tready;
  logic        b_tvalid = 1'b0, b_tlast = 1'b0, b_tuser = 1'b0, b_tready;
  logic [23:0] a_mdata;
  logic [39:0] b_mdata;
  logic        a_mvalid, a_mlast, a_muser, a_err, a_mready = 1'b1;
  logic        b_mvalid, b_mlast, b_muser, b_err, b_mready = 1'b1;

  axis_line_window #(.DATA_WIDTH(8), .ROWS(3), .MAX_WIDTH(16), .IMG_HEIGHT(4)) dut_a (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
    .s_axis_tlast(a_tlast), .s_axis_tuser(a_tuser),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
    .m_axis_tlast(a_mlast), .m_axis_tuser(a_muser), .frame_err(a_err));

  axis_line_window #(.DATA_WIDTH(8), .ROWS(5), .MAX_WIDTH(16), .IMG_HEIGHT(6)) dut_b (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser), .frame_err(b_err));

  int    total = 0, bad = 0, cyc = 0;
  int    a_beats = 0, b_beats = 0, stall_viol = 0, a_first_cyc = 0, a_last_cyc = 0;
  bit    chk_a = 1'b1, cap_en = 1'b0, rand_rdy = 1'b0;
  beat_t qa[$], qb[$], cap[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    a_mready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    b_mready = 1'b1;
  end

  // Output monitors: sampled on the falling edge, the handshake completes at the next rising edge.
  initial begin
    beat_t g, e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (a_mvalid && !a_mready && a_tready) stall_viol++;
        if (a_mvalid && a_mready) begin
          g.d = 64'(a_mdata); g.l = a_mlast; g.u = a_muser;
          a_beats++;
          if (a_beats == 1) a_first_cyc = cyc;
          a_last_cyc = cyc;
          if (cap_en) cap.push_back(g);
          if (chk_a) begin
            if (qa.size() == 0) begin
              total++; bad++;
              $display("FAIL a_extra_beat: got %h expected no beat", g.d);
            end else begin
              e = qa.pop_front();
              check("a_beat", {g.u, g.l, g.d[61:0]}, {e.u, e.l, e.d[61:0]});
            end
          end
        end
      end
    end
  end

  initial begin
    beat_t g, e;
    forever begin
      @(negedge clk);
      if (!rst && b_mvalid && b_mready) begin
        g.d = 64'(b_mdata); g.l = b_mlast; g.u = b_muser;
        b_beats++;
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_extra_beat: got %h expected no beat", g.d);
        end else begin
          e = qb.pop_front();
          check("b_beat", {g.u, g.l, g.d[61:0]}, {e.u, e.l, e.d[61:0]});
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] d, input logic last, input logic user);
    int n;
    n = 0;
    if (!sel) begin a_tdata = d; a_tlast = last; a_tuser = user; a_tvalid = 1'b1; end
    else begin b_tdata = d; b_tlast = last; b_tuser = user; b_tvalid = 1'b1; end
    forever begin
      @(negedge clk);
      if (sel ? b_tready : a_tready) break;
      n++;
      if (n > 2000) begin
        total++; bad++;
        $display("FAIL accept_timeout: got tready=0 for %0d cycles expected acceptance", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!sel) a_tvalid = 1'b0; else b_tvalid = 1'b0;
  endtask

  task automatic send_lines(input bit sel, input int l0, input int l1, input int w, input int err_line);
    for (int l = l0; l < l1; l++)
      for (int c = 0; c < w; c++)
        send(sel, 8'(l * 16 + c), (l == err_line) ? (c == w - 2) : (c == w - 1), (l == 0 && c == 0));
  endtask

  // Reference: output line o is centred on input line o+rows-1; slice k is k lines older.
  task automatic push_exp(input bit sel, input int rows, input int h, input int w);
    beat_t e;
    int    l;
    for (int o = 0; o < h; o++)
      for (int c = 0; c < w; c++) begin
        e.d = '0;
        for (int k = 0; k < rows; k++) begin
          l = o + rows - 1 - k;
          if (l < h) e.d[k*8 +: 8] = 8'(l * 16 + c);
          else       e.d[k*8 +: 8] = REPL ? 8'((h - 1) * 16 + c) : 8'h00;
        end
        e.l = (c == w - 1);
        e.u = (o == 0 && c == 0);
        if (!sel) qa.push_back(e); else qb.push_back(e);
      end
  endtask

  task automatic drain(input bit sel, input string name);
    int n;
    n = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(name, 64'(sel ? qb.size() : qa.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish within 40000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    spot_t tbl [7];
    beat_t g;
    tbl[0] = '{0,  24'h001020, 24'h001020, 1'b0, 1'b1};
    tbl[1] = '{1,  24'h011121, 24'h011121, 1'b0, 1'b0};
    tbl[2] = '{3,  24'h031323, 24'h031323, 1'b1, 1'b0};
    tbl[3] = '{4,  24'h102030, 24'h102030, 1'b0, 1'b0};
    tbl[4] = '{8,  24'h203000, 24'h203030, 1'b0, 1'b0};
    tbl[5] = '{12, 24'h300000, 24'h303030, 1'b0, 1'b0};
    tbl[6] = '{15, 24'h330000, 24'h333333, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", 64'(a_mvalid), 64'd0);
    check("rst_tready", 64'(a_tready), 64'd0);
    check("rst_err",    64'(a_err),    64'd0);
    check("rst_mdata",  64'(a_mdata),  64'd0);
    check("rst_tlast_tuser", 64'({a_mlast, a_muser}), 64'd0);
    check("rst_b_mvalid", 64'(b_mvalid), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_tready", 64'(a_tready), 64'd1);

    // Frame A: continuous input and output.
    a_beats = 0; cap_en = 1'b1;
    push_exp(0, 3, 4, 4);
    send_lines(0, 0, 4, 4, -1);
    drain(0, "frameA_drain");
    cap_en = 1'b0;
    check("frameA_beats", 64'(a_beats), 64'd16);
    check("frameA_no_bubble", 64'(a_last_cyc - a_first_cyc), 64'd15);
    check("frameA_err", 64'(a_err), 64'd0);
    for (int i = 0; i < 7; i++) begin
      if (cap.size() > tbl[i].idx) begin
        g = cap[tbl[i].idx];
        check($sformatf("spot%0d_data", tbl[i].idx), g.d, REPL ? 64'(tbl[i].dr) : 64'(tbl[i].dz));
        check($sformatf("spot%0d_last", tbl[i].idx), 64'(g.l), 64'(tbl[i].l));
        check($sformatf("spot%0d_user", tbl[i].idx), 64'(g.u), 64'(tbl[i].u));
      end else begin
        total++; bad++;
        $display("FAIL spot%0d_missing: got %0d beats expected more than %0d", tbl[i].idx, cap.size(), tbl[i].idx);
      end
    end

    // Frame B: random downstream backpressure.
    rand_rdy = 1'b1; stall_viol = 0; a_beats = 0;
    push_exp(0, 3, 4, 4);
    send_lines(0, 0, 4, 4, -1);
    drain(0, "frameB_drain");
    rand_rdy = 1'b0;
    check("frameB_beats", 64'(a_beats), 64'd16);
    check("frameB_stall_tready", 64'(stall_viol), 64'd0);

    // Frame C: early tlast on line 2; D: clean frame clears the flag.
    a_beats = 0;
    push_exp(0, 3, 4, 4);
    send_lines(0, 0, 4, 4, 2);
    drain(0, "frameC_drain");
    check("frameC_err_set", 64'(a_err), 64'd1);
    check("frameC_beats", 64'(a_beats), 64'd16);
    push_exp(0, 3, 4, 4);
    send_lines(0, 0, 1, 4, -1);
    check("frameD_err_clear_at_sof", 64'(a_err), 64'd0);
    send_lines(0, 1, 4, 4, -1);
    drain(0, "frameD_drain");
    check("frameD_err", 64'(a_err), 64'd0);

    // Asynchronous reset in the middle of RUN with an output beat pending.
    chk_a = 1'b0;
    send_lines(0, 0, 2, 4, 1);
    for (int c = 0; c < 3; c++) send(0, 8'(32 + c), 1'b0, 1'b0);
    check("prerst_err", 64'(a_err), 64'd1);
    check("prerst_mvalid", 64'(a_mvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_mvalid", 64'(a_mvalid), 64'd0);
    check("midrst_err", 64'(a_err), 64'd0);
    check("midrst_tready", 64'(a_tready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    chk_a = 1'b1;
    a_beats = 0;
    push_exp(0, 3, 4, 4);
    send_lines(0, 0, 4, 4, -1);
    drain(0, "frameE_drain");
    check("frameE_beats", 64'(a_beats), 64'd16);
    check("frameE_err", 64'(a_err), 64'd0);

    // ROWS=5: tuser injected at line 2 col 1 restarts the fill.
    b_beats = 0;
    push_exp(1, 5, 6, 4);
    send_lines(1, 0, 2, 4, -1);
    send(1, 8'h20, 1'b0, 1'b0);
    send_lines(1, 0, 4, 4, -1);
    repeat (3) @(posedge clk);
    #1;
    check("b_no_output_during_fill", 64'(b_beats), 64'd0);
    send_lines(1, 4, 6, 4, -1);
    drain(1, "frameB5_drain");
    check("b_beats", 64'(b_beats), 64'd24);
    check("b_err", 64'(b_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_line_window.md
Name: axis_line_window

Overview:
- Parametrised successor to the fixed 3-row line-buffer shifter.
- Takes a single-channel AXI4-Stream video frame and emits a ROWS-tall vertical pixel column every output beat.
- All rows are packed into one output stream, so the downstream kernel (3x3..7x7 filters) sees aligned rows by construction.
- Adds learned line width, full tvalid/tready backpressure, an explicit end-of-frame flush state machine and a sticky frame error flag.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- ROWS, 3, window height; legal range 2..7.
- MAX_WIDTH, 2048, maximum pixels per line; sets line-memory depth and counter width (clog2).
- IMG_HEIGHT, 480, input lines per frame; reaching it triggers the flush.

Ports:
- s_axis_aclk  in  1  sole clock.
- s_axis_areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- m_axis_tdata  out  ROWS*DATA_WIDTH  slice k = pixel from k lines ago; k=0 is the current line.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last column of an output line.
- m_axis_tuser  out  1  first beat of an output frame.
- frame_err  out  1  sticky line-length/overflow error; cleared at each accepted tuser.

Behaviour:
- Reset: state=IDLE. m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, frame_err and s_axis_tready all 0 while reset is asserted; all counters 0. Line memory contents are not reset.
- Handshake: input accepted when s_axis_tvalid & s_axis_tready. Output register advances when !m_axis_tvalid | m_axis_tready. s_axis_tready = that advance condition in FILL/RUN; 1 in IDLE; 0 in FLUSH.
- Memory: ROWS-1 line memories, each depth MAX_WIDTH, addressed by column counter col. Read-before-write on every accepted pixel: row k+1 reads from memory k, and the new pixel shifts into memory 0 (memory k gets the old memory k-1 value).
- Latency: output beat registered exactly 1 cycle after input acceptance; no bubbles when tready is held high.
- IDLE: pixels without tuser are discarded. tuser beat -> FILL; that beat is treated as col 0 of line 0. frame_err is cleared.
- FILL: first ROWS-1 lines are written only; no output. Line 0's tlast latches width W=col+1. After line ROWS-2 ends -> RUN.
- RUN: each accepted pixel produces one output beat. m_axis_tuser=1 on the first RUN beat of the frame. m_axis_tlast=1 when col==W-1. After input line count reaches IMG_HEIGHT -> FLUSH.
- FLUSH: ROWS-1 synthetic lines of W beats each, generated at the output rate, with zero input. Flush line f (1..ROWS-1) drives slices 0..f-1 with pad value 0; slices f..ROWS-1 come from memory as normal. After the last flush beat is accepted -> IDLE.
- Total output lines per frame = IMG_HEIGHT.
- Line-length rules:
  - tlast with col!=W-1 (early), or col reaching W-1 without tlast (late): set frame_err. Line end is taken at col==W-1 and col wraps to 0; input tlast is ignored when it disagrees.
  - W>MAX_WIDTH on line 0: set frame_err and clamp W to MAX_WIDTH.
- tuser during FILL/RUN (mid-frame restart): abandon the current frame and treat the beat as line 0 col 0 in FILL. Any pending output beat still completes its handshake. tuser during FLUSH is stalled (tready=0) and seen after the return to IDLE.
- Asynchronous reset mid-frame: immediately returns to IDLE; the output stream is cut without tlast.

Optional Feature:
- Macro LINE_WINDOW_BORDER_REPLICATE_EN.
- Defined: during FLUSH, padded slices 0..f-1 replicate slice f (the newest real line) instead of 0, giving edge-replicated bottom borders.
- Undefined: pad is zero. Flush timing is the same either way.

Test Plan:
- ROWS=3, IMG_HEIGHT=4, W=4, pixel=line*16+col, tready=1 -> 4 output lines of 4 beats. Output line 0 col 1 = {0x01,0x11,0x21} (slice2..0). tuser on the first beat only; tlast every 4th beat.
- Same frame, macro undefined -> flush line 2 (f=2) col 0 = {0x30,0x00,0x00}. Macro defined -> {0x30,0x30,0x30}.
- Random m_axis_tready at 50% -> output sequence identical to the tready=1 run. No beat lost or duplicated; s_axis_tready low whenever the output is stalled.
- Line 2 ends with tlast at col 2 (W=4) -> frame_err=1, output still 4-beat lines. The next tuser clears frame_err.
- tuser injected at line 2 col 1 of ROWS=5 -> no output until 4 new lines are filled; the new frame's first output carries tuser.
- s_axis_areset pulsed mid-RUN -> within the reset, m_axis_tvalid=0 and frame_err=0. The next frame is processed normally.
